fpga_ip_wb_xbar: RTL
====================

FPGA_IP_WB_XBAR -- requirements
Module: fpga_ip_wb_xbar

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, number of IP slots (1..8).
REQ-002 SHALL have parameter APERWIDTH, default 17, Wishbone byte-address width.
REQ-003 SHALL have parameter APERSIZE, default 10, per-slot aperture bits; slot match uses ADR[APERWIDTH-1:APERSIZE].
REQ-004 SHALL have parameter SLOT_BASE, default {17'h05000,17'h03000,17'h02000,17'h01000}, packed NUM_SLOTS*APERWIDTH base addresses, slot 0 in LSBs.
REQ-005 SHALL have parameter DEFAULT_READ_VALUE, default 32'hBAD_FAB_AC, data returned on unmapped or timed-out access.
REQ-006 SHALL have parameter TIMEOUT_WIDTH, default 4, timeout counter width.
REQ-007 SHALL have parameter TIMEOUT_CYCLES, default 15, maximum WAIT cycles (1..2^TIMEOUT_WIDTH-1).
REQ-008 SHALL have ports: WBs_CLK_i in 1 clock; WBs_RST_i in 1 synchronous active-high reset; WBs_ADR_i in APERWIDTH address; WBs_CYC_i in 1 cycle; WBs_STB_i in 1 strobe; WBs_DAT_o out 32 read data; WBs_ACK_o out 1 acknowledge; slot_cyc_o out NUM_SLOTS per-slot select; slot_ack_i in NUM_SLOTS per-slot ack; slot_dat_i in NUM_SLOTS*32 per-slot read data; err_clr_i in 1 error clear; err_intr_o out 1 sticky error; err_adr_o out APERWIDTH failing address.
REQ-009 SHALL use one clock, WBs_CLK_i; reset WBs_RST_i is synchronous and active-high.

Function
REQ-010 SHALL implement FSM IDLE, WAIT, RESP; all outputs registered.
REQ-011 IDLE: on CYC&STB, SHALL latch address and decoded slot; matched -> WAIT, unmatched -> RESP with DEFAULT_READ_VALUE.
REQ-012 Decode SHALL pick lowest-index matching slot when bases overlap.
REQ-013 slot_cyc_o SHALL be one-hot for the latched slot only while in WAIT, zero otherwise.
REQ-014 WAIT: only the selected slot's slot_ack_i SHALL be honoured; on it, capture its slot_dat_i word and -> RESP.
REQ-015 RESP SHALL last exactly one cycle with WBs_ACK_o=1 and captured data on WBs_DAT_o, then -> IDLE; WBs_ACK_o SHALL be 0 in all other states.
REQ-016 Latency: slot ack in cycle k -> WBs_ACK_o in cycle k+1; unmapped request sampled at edge E -> WBs_ACK_o in the cycle after E.
REQ-017 Timeout counter SHALL clear on WAIT entry and increment each WAIT cycle; at count TIMEOUT_CYCLES-1 without ack, SHALL -> RESP with DEFAULT_READ_VALUE.
REQ-018 Ack in the same cycle as timeout SHALL win: slot data returned, no error.
REQ-019 CYC deasserted in WAIT SHALL abort to IDLE: no ack, no error, slot_cyc_o 0 next cycle.
REQ-020 Unmapped access or timeout SHALL set err_intr_o and load err_adr_o with the latched address; err_clr_i clears err_intr_o; a simultaneous new error SHALL win over clear.

Reset
REQ-021 Reset SHALL force IDLE and set WBs_ACK_o=0, WBs_DAT_o=0, slot_cyc_o=0, err_intr_o=0, err_adr_o=0, counter=0, including mid-transaction.

Configuration
REQ-022 With WB_XBAR_TIMEOUT_EN defined, timeout per REQ-017 is built; without it the counter is absent, WAIT persists until ack or CYC drop, and only unmapped accesses set err_intr_o.

Structure
REQ-023 Package fpga_ip_wb_xbar_pkg SHALL hold the FSM state typedef, data width 32, and DEFAULT_READ_VALUE default.
REQ-024 Combinational priority address decoder SHALL be sub-module fpga_ip_wb_addr_decode.

Verification (NUM_SLOTS=4, defaults)
REQ-025 Read 0x03004, slot 2 acks 2 cycles after select with 0x12345678 -> slot_cyc_o=4'b0100, WBs_ACK_o one cycle later with 0x12345678, err_intr_o=0.
REQ-026 Read 0x07000 -> WBs_ACK_o next cycle, data 0xBADFABAC, err_intr_o=1, err_adr_o=0x07000.
REQ-027 Read 0x02010, slot 1 never acks -> ack after 15 WAIT cycles, data 0xBADFABAC, err_adr_o=0x02010; err_clr_i pulse -> err_intr_o=0.
REQ-028 Slot 1 acks in 15th WAIT cycle with 0xCAFE0001 -> data 0xCAFE0001, err_intr_o=0.
REQ-029 CYC dropped in 3rd WAIT cycle -> slot_cyc_o=0 next cycle, no ack; WBs_RST_i in WAIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/fpga_ip_wb_xbar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpga_ip_wb_xbar_pkg
// Description : Shared definitions for the Wishbone IP-slot crossbar: data
//               width, default read-back word and the three-state FSM
//               encoding used by fpga_ip_wb_xbar.
// Revision    : 1.0 - initial release
// ============================================================================
package fpga_ip_wb_xbar_pkg;

    localparam int unsigned c_DATA_WIDTH         = 32;
    localparam logic [31:0] c_DEFAULT_READ_VALUE = 32'hBAD_FAB_AC;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_WAIT = 2'd1;
    localparam state_t c_ST_RESP = 2'd2;

endpackage : fpga_ip_wb_xbar_pkg
`default_nettype wire

// File: rtl/fpga_ip_wb_addr_decode.sv
`default_nettype none
// ============================================================================
// Module      : fpga_ip_wb_addr_decode
// Description : Combinational priority address decoder. Compares the aperture
//               tag (address bits above APERSIZE) against every slot base and
//               returns a one-hot select of the lowest-index matching slot.
// Ports       : i_adr_hi - address tag, ADR[APERWIDTH-1:APERSIZE]
//               o_hit    - at least one slot matches
//               o_sel    - one-hot select of the winning slot (0 when no hit)
// Revision    : 1.0 - initial release
// ============================================================================
module fpga_ip_wb_addr_decode
    import fpga_ip_wb_xbar_pkg::*;
#(
    parameter int                            NUM_SLOTS = 4,
    parameter int                            APERWIDTH = 17,
    parameter int                            APERSIZE  = 10,
    parameter logic [NUM_SLOTS*APERWIDTH-1:0] SLOT_BASE =
        {17'h05000, 17'h03000, 17'h02000, 17'h01000}
)(
    input  logic [APERWIDTH-APERSIZE-1:0] i_adr_hi,
    output logic                          o_hit,
    output logic [NUM_SLOTS-1:0]          o_sel
);

    localparam int c_TAG_W = APERWIDTH - APERSIZE;

    logic [NUM_SLOTS-1:0] w_match;

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_match
            assign w_match[gi] =
                (i_adr_hi == SLOT_BASE[gi*APERWIDTH+APERSIZE +: c_TAG_W]);
        end
    endgenerate

    // Isolate the lowest set bit: overlapping apertures resolve to the
    // lowest-index slot.
    assign o_sel = w_match & (~w_match + NUM_SLOTS'(1));
    assign o_hit = |w_match;

endmodule : fpga_ip_wb_addr_decode
`default_nettype wire

// File: rtl/fpga_ip_wb_xbar.sv
`default_nettype none
// ============================================================================
// Module      : fpga_ip_wb_xbar
// Description : Wishbone read crossbar fanning one master out to NUM_SLOTS IP
//               slots by address aperture. Unmapped accesses (and, when
//               WB_XBAR_TIMEOUT_EN is defined, slots that never acknowledge)
//               complete with DEFAULT_READ_VALUE and raise a sticky error that
//               records the failing address.
// Build macro : WB_XBAR_TIMEOUT_EN - include the WAIT-state timeout counter.
// Ports       : WBs_CLK_i / WBs_RST_i      - clock, sync active-high reset
//               WBs_ADR_i/CYC_i/STB_i      - master request
//               WBs_DAT_o/ACK_o            - registered read response
//               slot_cyc_o                 - one-hot slot select (WAIT only)
//               slot_ack_i / slot_dat_i    - per-slot ack and read data
//               err_clr_i                  - clears err_intr_o
//               err_intr_o / err_adr_o     - sticky error and its address
// Revision    : 1.0 - initial release
// ============================================================================
module fpga_ip_wb_xbar
    import fpga_ip_wb_xbar_pkg::*;
#(
    parameter int                             NUM_SLOTS          = 4,
    parameter int                             APERWIDTH          = 17,
    parameter int                             APERSIZE           = 10,
    parameter logic [NUM_SLOTS*APERWIDTH-1:0] SLOT_BASE          =
        {17'h05000, 17'h03000, 17'h02000, 17'h01000},
    parameter logic [c_DATA_WIDTH-1:0]        DEFAULT_READ_VALUE = c_DEFAULT_READ_VALUE,
    parameter int                             TIMEOUT_WIDTH      = 4,
    parameter int                             TIMEOUT_CYCLES     = 15
)(
    input  logic                              WBs_CLK_i,
    input  logic                              WBs_RST_i,
    input  logic [APERWIDTH-1:0]              WBs_ADR_i,
    input  logic                              WBs_CYC_i,
    input  logic                              WBs_STB_i,
    output logic [c_DATA_WIDTH-1:0]           WBs_DAT_o,
    output logic                              WBs_ACK_o,
    output logic [NUM_SLOTS-1:0]              slot_cyc_o,
    input  logic [NUM_SLOTS-1:0]              slot_ack_i,
    input  logic [NUM_SLOTS*c_DATA_WIDTH-1:0] slot_dat_i,
    input  logic                              err_clr_i,
    output logic                              err_intr_o,
    output logic [APERWIDTH-1:0]              err_adr_o
);

    state_t                   r_state;
    logic [NUM_SLOTS-1:0]     r_slot_cyc;
    logic                     r_ack;
    logic [c_DATA_WIDTH-1:0]  r_dat;
    logic                     r_err;
    logic [APERWIDTH-1:0]     r_err_adr;

    logic                     w_dec_hit;
    logic [NUM_SLOTS-1:0]     w_dec_sel;
    logic                     w_sel_ack;
    logic [c_DATA_WIDTH-1:0]  w_sel_dat;
    logic                     w_timeout;
    logic [APERWIDTH-1:0]     w_req_adr;

    fpga_ip_wb_addr_decode #(
        .NUM_SLOTS (NUM_SLOTS),
        .APERWIDTH (APERWIDTH),
        .APERSIZE  (APERSIZE),
        .SLOT_BASE (SLOT_BASE)
    ) u_addr_decode (
        .i_adr_hi (WBs_ADR_i[APERWIDTH-1:APERSIZE]),
        .o_hit    (w_dec_hit),
        .o_sel    (w_dec_sel)
    );

    // r_slot_cyc is non-zero only in WAIT and then holds the latched slot,
    // so it doubles as the mask that ignores acks from other slots.
    assign w_sel_ack = |(slot_ack_i & r_slot_cyc);

    always_comb begin
        w_sel_dat = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (r_slot_cyc[i]) begin
                w_sel_dat = slot_dat_i[i*c_DATA_WIDTH +: c_DATA_WIDTH];
            end
        end
    end

`ifdef WB_XBAR_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] r_tcnt;
    logic [APERWIDTH-1:0]     r_req_adr;

    // The counter sits at zero outside WAIT, so it starts from zero on every
    // WAIT entry; the request address is kept only to report a timeout.
    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) begin
            r_tcnt    <= '0;
            r_req_adr <= '0;
        end else begin
            if ((r_state == c_ST_IDLE) && WBs_CYC_i && WBs_STB_i) begin
                r_req_adr <= WBs_ADR_i;
            end
            if (r_state == c_ST_WAIT) begin
                r_tcnt <= r_tcnt + TIMEOUT_WIDTH'(1);
            end else begin
                r_tcnt <= '0;
            end
        end
    end

    assign w_timeout = (r_tcnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));
    assign w_req_adr = r_req_adr;
`else
    assign w_timeout = 1'b0;
    assign w_req_adr = '0;
`endif

    // Priority in WAIT: CYC drop aborts first, then the slot ack, then the
    // timeout, so an ack arriving on the final WAIT cycle still returns data.
    // A newly detected error is assigned after the clear and therefore wins.
    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) begin
            r_state    <= c_ST_IDLE;
            r_slot_cyc <= '0;
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_err      <= 1'b0;
            r_err_adr  <= '0;
        end else begin
            r_ack <= 1'b0;
            if (err_clr_i) begin
                r_err <= 1'b0;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (WBs_CYC_i && WBs_STB_i) begin
                        if (w_dec_hit) begin
                            r_slot_cyc <= w_dec_sel;
                            r_state    <= c_ST_WAIT;
                        end else begin
                            r_ack     <= 1'b1;
                            r_dat     <= DEFAULT_READ_VALUE;
                            r_err     <= 1'b1;
                            r_err_adr <= WBs_ADR_i;
                            r_state   <= c_ST_RESP;
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (!WBs_CYC_i) begin
                        r_slot_cyc <= '0;
                        r_state    <= c_ST_IDLE;
                    end else if (w_sel_ack) begin
                        r_slot_cyc <= '0;
                        r_ack      <= 1'b1;
                        r_dat      <= w_sel_dat;
                        r_state    <= c_ST_RESP;
                    end else if (w_timeout) begin
                        r_slot_cyc <= '0;
                        r_ack      <= 1'b1;
                        r_dat      <= DEFAULT_READ_VALUE;
                        r_err      <= 1'b1;
                        r_err_adr  <= w_req_adr;
                        r_state    <= c_ST_RESP;
                    end
                end
                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_slot_cyc <= '0;
                    r_state    <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign WBs_DAT_o  = r_dat;
    assign WBs_ACK_o  = r_ack;
    assign slot_cyc_o = r_slot_cyc;
    assign err_intr_o = r_err;
    assign err_adr_o  = r_err_adr;

endmodule : fpga_ip_wb_xbar
`default_nettype wire
